// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, branch/jump and data-memory waits.
// Define HAZARD_STATS_EN to build the saturating stall/flush statistics counters.
module pipe_hazard_ctrl #(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             id_jump,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rt,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_we,
  output logic             idex_flush,
  output logic             exmem_we,
  output logic             mem_timeout,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_LU_STALL = 2'd1;
  localparam logic [1:0] ST_MEM_WAIT = 2'd2;
  localparam logic [1:0] ST_ERR      = 2'd3;
  localparam logic [7:0] MAX_WAIT_C  = 8'(MAX_WAIT);

  logic [1:0] state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       mem_timeout_q, mem_timeout_d;
  logic       lu, issue, lu_en;

  // Memory handshake: an access completes in the cycle where mem_req and
  // mem_ready are both high; mem_ready alone carries no meaning.
  assign lu = ex_memread && (ex_rt != 5'd0) &&
              ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

  always_comb begin
    pc_we         = 1'b1;
    ifid_we       = 1'b1;
    ifid_flush    = 1'b0;
    idex_we       = 1'b1;
    idex_flush    = 1'b0;
    exmem_we      = 1'b1;
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    issue         = 1'b0;
    lu_en         = 1'b0;
    case (state_q)
      ST_RUN, ST_LU_STALL: begin
        if (mem_req && !mem_ready) begin
          {pc_we, ifid_we, idex_we, exmem_we} = 4'b0000;
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = 8'd1;
        end else begin
          issue = 1'b1;
          // The bubble inserted by a load-use stall is already in EX.
          lu_en = (state_q == ST_RUN);
        end
      end
      ST_MEM_WAIT: begin
        if (mem_req && mem_ready) begin
          issue      = 1'b1;
          lu_en      = 1'b1;
          wait_cnt_d = 8'd0;
        end else begin
          {pc_we, ifid_we, idex_we, exmem_we} = 4'b0000;
          if (wait_cnt_q == MAX_WAIT_C) state_d = ST_ERR;
          else wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      default: begin
        {pc_we, ifid_we, idex_we, exmem_we} = 4'b0000;
      end
    endcase
    if (issue) begin
      state_d = ST_RUN;
      if (ex_branch_taken) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (lu_en && lu) begin
        pc_we      = 1'b0;
        ifid_we    = 1'b0;
        idex_flush = 1'b1;
        state_d    = ST_LU_STALL;
      end else if (id_jump) begin
        ifid_flush = 1'b1;
      end
    end
    mem_timeout_d = mem_timeout_q || (state_d == ST_ERR);
    if (reset) begin
      {pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we} = 6'b000000;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_RUN;
      wait_cnt_q    <= 8'd0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  assign state_o     = state_q;
  assign mem_timeout = mem_timeout_q;

`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!pc_we && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
    if (ifid_flush && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;
`else
  assign stall_count = '0;
  assign flush_count = '0;
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage MIPS pipeline.
- Drives the write-enable and bubble/flush controls of PC, IF/ID, ID/EX and EX/MEM from three sources:
  - load-use hazards, from ID operands against ID/EX load destination;
  - taken branches and jumps;
  - multi-cycle data-memory waits with timeout.
- Sits beside the pipeline registers. Purely control; carries no datapath.

Parameters:
- MAX_WAIT, 15, maximum consecutive MEM_WAIT cycles before timeout (legal range 2..255).
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- id_rs  in  5  rs field of the instruction in ID.
- id_rt  in  5  rt field of the instruction in ID.
- id_uses_rt  in  1  ID instruction reads rt as a source.
- id_jump  in  1  jump decoded in ID.
- ex_memread  in  1  instruction in EX is a load.
- ex_rt  in  5  load destination held in ID/EX (Ins20).
- ex_branch_taken  in  1  branch resolved taken in EX.
- mem_req  in  1  MEM stage accessing data memory this cycle.
- mem_ready  in  1  data memory completes access this cycle.
- pc_we  out  1  PC load enable.
- ifid_we  out  1  IF/ID load enable.
- ifid_flush  out  1  load NOP into IF/ID.
- idex_we  out  1  ID/EX load enable.
- idex_flush  out  1  load bubble (WB/MEM/EX controls = 0) into ID/EX.
- exmem_we  out  1  EX/MEM and MEM/WB load enable.
- mem_timeout  out  1  sticky timeout error.
- state_o  out  2  current state: 0 RUN, 1 LU_STALL, 2 MEM_WAIT, 3 ERR.
- stall_count  out  CNT_W  cycles with pc_we=0 (see Optional Feature).
- flush_count  out  CNT_W  cycles with ifid_flush=1 (see Optional Feature).

Behaviour:
- Reset: state RUN, wait_cnt=0, mem_timeout=0, counters 0.
- While reset is high, all *_we=0, all flushes=0 and state_o=0.
- State, wait_cnt, mem_timeout and counters are registered.
- Enables and flushes are combinational from state plus current inputs (same-cycle Mealy). Zero-cycle latency from hazard to control.
- Load-use condition LU = ex_memread & (ex_rt!=0) & (ex_rt==id_rs | (id_uses_rt & ex_rt==id_rt)).
- Default outputs: all *_we=1, all flushes=0.
- RUN, priority order (first match wins):
  1. mem_req & !mem_ready: all four *_we=0. Next state MEM_WAIT, wait_cnt=1.
  2. ex_branch_taken: ifid_flush=1, idex_flush=1, pc_we=1. LU is ignored because the wrong-path ID instruction is squashed.
  3. LU: pc_we=0, ifid_we=0, idex_flush=1. Next state LU_STALL.
  4. id_jump: ifid_flush=1.
- LU_STALL:
  - Exactly one cycle, with default outputs. LU is not re-evaluated because the bubble is in EX.
  - Branch/jump/mem rules apply as in RUN.
  - Returns to RUN, or goes to MEM_WAIT under rule 1.
- MEM_WAIT:
  - If mem_ready: release this cycle. Outputs are evaluated with RUN rules 2–4 against the held inputs, so a taken branch frozen in EX flushes on the release cycle. Next state RUN, wait_cnt=0.
  - Else: all *_we=0, flushes=0, wait_cnt+1.
  - If wait_cnt==MAX_WAIT without ready: next state ERR.
- ERR: all *_we=0, flushes=0, mem_timeout=1. Exited only by reset.
- mem_ready without mem_req is ignored.
- Reset asserted mid-MEM_WAIT or mid-stall returns immediately to the reset state.

Optional Feature:
- Macro HAZARD_STATS_EN.
- Defined:
  - stall_count increments each non-reset cycle with pc_we=0.
  - flush_count increments each cycle with ifid_flush=1.
  - Both saturate at all-ones and clear on reset.
- Undefined: both outputs tied to 0 and the counter logic is removed. Control behaviour is identical either way.

Test Plan:
- Load-use: ex_memread=1, ex_rt=8, id_rs=8. Required: pc_we=0, ifid_we=0, idex_flush=1 for one cycle, then state LU_STALL, then RUN with all we=1. With ex_rt=0, no stall.
- Taken branch with LU: ex_branch_taken=1 plus an LU match. Required: ifid_flush=1, idex_flush=1, pc_we=1, and no LU_STALL entry.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles, then ready. Required: all we=0 for 3 cycles; we=1 on the ready cycle; state 2 then 0.
- Timeout, MAX_WAIT=4: mem_req=1 with ready never asserted. Required: state ERR after 4 wait cycles; mem_timeout=1 held; a later mem_ready is ignored; reset clears it.
- Reset mid-wait: assert reset asynchronously in cycle 2 of MEM_WAIT. Required: state 0 and mem_timeout=0 without a clock edge.
- HAZARD_STATS_EN defined: 1 LU stall, 1 jump and 3 wait cycles. Required: stall_count=4 and flush_count=1. With the macro undefined, both read 0.
